unary_mult_scheduler: RTL and testbench
=======================================

// Module: unary_mult_scheduler
// PURPOSE
//  Shares one unary_shift_multiplier among NUM_REQ requesters. Round-robin
//  arbitration, binary->serial-unary operand feed, ones-count of the serial
//  product back to binary, and return of the tagged result on a valid/ready port.
//  Sits between the binary request fabric and the unary MAC datapath.
// PARAMETERS
//  BIN_BITS     4   operand width; U_BITS = 1<<BIN_BITS unary slots (match multiplier)
//  NUM_REQ      4   number of requesters (>=2)
//  DRAIN_CYCLES 288 cycles after feed during which mult_out ones are counted
//                   (default U_BITS*(U_BITS+2))
// PORTS
//  clk          in   1                clock
//  reset_n      in   1                async active-low reset
//  req_valid    in   NUM_REQ          per-requester request
//  req_a        in   NUM_REQ*BIN_BITS operand A, requester i at [i*BIN_BITS +: BIN_BITS]
//  req_b        in   NUM_REQ*BIN_BITS operand B, same packing
//  req_ready    out  NUM_REQ          one-hot accept pulse
//  mult_a       out  1                serial unary A -> multiplier in_a
//  mult_b       out  1                serial unary B -> multiplier in_b
//  mult_valid   out  1                -> multiplier in_valid
//  mult_out     in   1                multiplier serial unary product
//  rsp_valid    out  1                result available
//  rsp_product  out  2*BIN_BITS       binary product
//  rsp_id       out  $clog2(NUM_REQ)  index of granted requester
//  rsp_ready    in   1                consumer accepts result
// BEHAVIOUR
//  - Reset (reset_n low): all outputs 0; state IDLE; RR pointer 0; counters 0.
//    Asynchronous assert, synchronous release; mid-op reset abandons the job
//    silently (no response).
//  - FSM IDLE -> FEED -> DRAIN -> RESP -> IDLE.
//  - IDLE: if any req_valid, grant first set bit at/after RR pointer (wrapping).
//    Same cycle: req_ready[g]=1 and operands/id captured. Next cycle: FEED.
//    RR pointer <= (g+1) mod NUM_REQ. No req_valid: stay, no pointer change.
//  - FEED: exactly U_BITS cycles, mult_valid=1; slot k (k=0..U_BITS-1):
//    mult_a=(k<A), mult_b=(k<B); thermometer, ones first. Then DRAIN.
//  - DRAIN: exactly DRAIN_CYCLES cycles, mult_valid=0, mult_a=mult_b=0.
//    Ones counter increments on each cycle mult_out=1; saturates at 2^(2*BIN_BITS)-1.
//    mult_out ignored outside DRAIN. Then RESP.
//  - RESP: rsp_valid=1; rsp_product=count, rsp_id=g, both stable until
//    rsp_valid&&rsp_ready. On handshake: next cycle IDLE, rsp_valid=0, counter cleared.
//  - Only one job in flight; req_ready stays 0 outside IDLE. Requesters hold
//    req_valid/operands until req_ready; a deasserted req_valid is not granted.
//  - Zero operand: feed still runs full U_BITS slots; product 0.
//  - Latency grant->rsp_valid: 1+U_BITS+DRAIN_CYCLES cycles. Min job period:
//    that plus 1 (RESP->IDLE).
// CONFIGURATION
//  UNARY_MULT_SCHED_PERF_EN defined: extra outputs perf_jobs[31:0] (jobs
//   completed at response handshake, wraps at 2^32) and perf_stall[31:0]
//   (cycles in RESP with rsp_ready=0, saturating); both reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING (BIN_BITS=4, NUM_REQ=4, real multiplier attached, rsp_ready=1 unless noted)
//  1. Req 2 only, A=3, B=5 -> req_ready=4'b0100 one cycle; 16 FEED cycles with
//     mult_a=1 for slots 0-2; rsp_product=15, rsp_id=2, 1+16+288 cycles after grant.
//  2. All 4 requesting continuously, distinct operands -> grant order 0,1,2,3,0;
//     each product correct.
//  3. A=0, B=9 and A=15, B=15 -> products 0 and 225 (no saturation).
//  4. rsp_ready held 0 for 20 cycles in RESP -> rsp_valid/product/id stable,
//     no new grant; perf_stall=20 with PERF_EN.
//  5. reset_n pulsed low mid-FEED -> outputs 0 immediately, RR pointer 0;
//     next request served normally, no stale response.
//  6. Req 1 drops req_valid while job for req 0 runs; req 3 waiting -> next grant is 3.

Source files
------------

// File: rtl/unary_mult_scheduler.sv
// Shares one serial unary multiplier among NUM_REQ requesters (round-robin grant, thermometer feed, ones count).
// Latency: grant -> rsp_valid is 1 + U_BITS + DRAIN_CYCLES cycles; one job in flight at a time.
// Backpressure: rsp_valid/product/id hold until rsp_ready; no new grant (req_ready=0) until the response is taken.
//
// Ports:
//   clk, reset_n              clock, async active-low reset (synchronous release)
//   req_valid/req_a/req_b     per-requester request, operands packed [i*BIN_BITS +: BIN_BITS]
//   req_ready                 one-hot accept pulse, only ever asserted in IDLE
//   mult_a/mult_b/mult_valid  serial thermometer operands to the multiplier
//   mult_out                  serial unary product, counted only while draining
//   rsp_valid/rsp_product/rsp_id/rsp_ready  tagged binary result, valid/ready
//   perf_jobs/perf_stall      present only when UNARY_MULT_SCHED_PERF_EN is defined
module unary_mult_scheduler #(
  parameter int BIN_BITS     = 4,
  parameter int NUM_REQ      = 4,
  parameter int DRAIN_CYCLES = (1 << BIN_BITS) * ((1 << BIN_BITS) + 2)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*BIN_BITS-1:0]   req_a,
  input  logic [NUM_REQ*BIN_BITS-1:0]   req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          mult_a,
  output logic                          mult_b,
  output logic                          mult_valid,
  input  logic                          mult_out,
  output logic                          rsp_valid,
  output logic [2*BIN_BITS-1:0]         rsp_product,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  input  logic                          rsp_ready
`ifdef UNARY_MULT_SCHED_PERF_EN
  ,
  output logic [31:0]                   perf_jobs,
  output logic [31:0]                   perf_stall
`endif
);

  localparam int U_BITS  = 1 << BIN_BITS;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int PROD_W  = 2 * BIN_BITS;
  localparam int CNT_MAX = (DRAIN_CYCLES > U_BITS) ? DRAIN_CYCLES : U_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [PROD_W-1:0] PROD_SAT = '1;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   ones_q, ones_d;
  logic [BIN_BITS-1:0] a_q, a_d, b_q, b_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;

  // Round-robin pick: first valid requester at or after the pointer, wrapping.
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ones_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    req_ready   = '0;
    mult_valid  = 1'b0;
    mult_a      = 1'b0;
    mult_b      = 1'b0;
    rsp_valid   = 1'b0;
    rsp_product = '0;
    rsp_id      = '0;

    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          // The state register is held in IDLE during reset; gating keeps the
          // accept pulse from leaking out while reset_n is low.
          req_ready[gnt_idx] = reset_n;
          a_d     = req_a[gnt_idx*BIN_BITS +: BIN_BITS];
          b_d     = req_b[gnt_idx*BIN_BITS +: BIN_BITS];
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          cnt_d   = '0;
          ones_d  = '0;
          state_d = S_FEED;
        end
      end

      S_FEED: begin
        // Thermometer code, ones first: slot k carries (k < operand).
        mult_valid = 1'b1;
        mult_a     = (cnt_q < CNT_W'(a_q));
        mult_b     = (cnt_q < CNT_W'(b_q));
        if (cnt_q == CNT_W'(U_BITS - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DRAIN: begin
        if (mult_out && (ones_q != PROD_SAT)) begin
          ones_d = ones_q + PROD_W'(1);
        end
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        rsp_valid   = 1'b1;
        rsp_product = ones_q;
        rsp_id      = id_q;
        if (rsp_ready) begin
          ones_d  = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef UNARY_MULT_SCHED_PERF_EN
  logic [31:0] perf_jobs_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_jobs_q  <= '0;
      perf_stall_q <= '0;
    end else if (state_q == S_RESP) begin
      if (rsp_ready) begin
        perf_jobs_q <= perf_jobs_q + 32'd1;
      end else if (perf_stall_q != 32'hFFFF_FFFF) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_jobs  = perf_jobs_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_unary_mult_scheduler.sv
module tb_unary_mult_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        mult_a;
  logic        mult_b;
  logic        mult_valid;
  logic        mult_out;
  logic        rsp_valid;
  logic [7:0]  rsp_product;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
`ifdef UNARY_MULT_SCHED_PERF_EN
  logic [31:0] perf_jobs;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  unary_mult_scheduler #(.BIN_BITS(4), .NUM_REQ(4), .DRAIN_CYCLES(288)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_valid  (mult_valid),
    .mult_out    (mult_out),
    .rsp_valid   (rsp_valid),
    .rsp_product (rsp_product),
    .rsp_id      (rsp_id),
    .rsp_ready   (rsp_ready)
`ifdef UNARY_MULT_SCHED_PERF_EN
    ,
    .perf_jobs   (perf_jobs),
    .perf_stall  (perf_stall)
`endif
  );

  // Behavioural serial unary multiplier: counts thermometer ones during the
  // feed, then streams A*B ones starting shortly after the feed ends.
  logic [4:0] na, nb;
  logic [8:0] rem;
  logic       feeding;
  logic       noise_en;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      na <= '0; nb <= '0; rem <= '0; feeding <= 1'b0;
    end else if (mult_valid) begin
      if (!feeding) begin
        na <= {4'b0, mult_a};
        nb <= {4'b0, mult_b};
      end else begin
        na <= na + {4'b0, mult_a};
        nb <= nb + {4'b0, mult_b};
      end
      feeding <= 1'b1;
    end else if (feeding) begin
      rem     <= na * nb;
      feeding <= 1'b0;
    end else if (rem != 0) begin
      rem <= rem - 9'd1;
    end
  end

  // Optional spurious ones during FEED: a correct scheduler ignores them.
  assign mult_out = (rem != 0) | (noise_en & mult_valid);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int jobs_since_reset = 0;

  always @(posedge clk) cyc++;

  typedef struct {int id; int prod;} exp_t;
  exp_t sb[$];
  exp_t e;

  typedef struct {int rq; int a; int b; int prod;} vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Response scoreboard.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_response");
      end else begin
        e = sb.pop_front();
        check("rsp_product", rsp_product, e.prod);
        check("rsp_id", rsp_id, e.id);
        jobs_since_reset++;
      end
    end
  end

  task automatic push(input int id, input int prod);
    exp_t x;
    x.id = id;
    x.prod = prod;
    sb.push_back(x);
  endtask

  task automatic set_op(input int rq, input int a, input int b);
    req_a[rq*4 +: 4] = 4'(a);
    req_b[rq*4 +: 4] = 4'(b);
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (|req_ready) begin
        for (int k = 0; k < 4; k++) if (req_ready[k]) g = k;
        check("grant_onehot", longint'($onehot(req_ready)), 1);
        return;
      end
    end
    fail_now("grant_timeout");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) return;
    end
    fail_now("drain_timeout");
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    sb.delete();
    jobs_since_reset = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, gc, bad, vcnt, p0, i0;
    bit found;
    logic [15:0] pa, pb;

    tbl[0] = '{0, 2, 7, 14};
    tbl[1] = '{1, 4, 4, 16};
    tbl[2] = '{2, 6, 3, 18};
    tbl[3] = '{3, 5, 11, 55};
    tbl[4] = '{0, 2, 7, 14};
    tbl[5] = '{1, 0, 9, 0};
    tbl[6] = '{3, 15, 15, 225};

    // Reset state, with requests pending during reset.
    reset_n   = 1'b0;
    req_valid = 4'hF;
    req_a     = 16'h1234;
    req_b     = 16'h5678;
    rsp_ready = 1'b1;
    noise_en  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_mult_valid", mult_valid, 0);
    check("rst_mult_a", mult_a, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_product", rsp_product, 0);
    check("rst_rsp_id", rsp_id, 0);
    req_valid = '0;
    reset_n   = 1'b1;

    // Single request from requester 2: 3 x 5.
    @(posedge clk); #1;
    set_op(2, 3, 5);
    req_valid = 4'b0100;
    wait_grant(g);
    gc = cyc;
    check("t1_req_ready", req_ready, 4'b0100);
    push(2, 15);
    @(posedge clk); #1;
    req_valid = '0;
    vcnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) check("t1_ready_pulse", req_ready, 0);
      pa[k] = mult_a;
      pb[k] = mult_b;
      vcnt += int'(mult_valid);
    end
    check("t1_feed_a", pa, 16'h0007);
    check("t1_feed_b", pb, 16'h001F);
    check("t1_feed_valid_cnt", vcnt, 16);
    @(negedge clk);
    check("t1_feed_end", mult_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (rsp_valid) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) fail_now("t1_rsp_timeout");
    else check("t1_latency", cyc - gc, 305);
    wait_drain();

    // All four requesting continuously: round-robin order 0,1,2,3,0.
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_op(tbl[i].rq, tbl[i].a, tbl[i].b);
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g);
      check("t2_grant_order", g, tbl[i].rq);
      push(tbl[i].rq, tbl[i].prod);
      if (i == 4) begin
        @(posedge clk); #1;
        req_valid = '0;
      end
    end
    wait_drain();

    // Boundary operands, with spurious ones injected during FEED.
    noise_en = 1'b1;
    for (int i = 5; i < 7; i++) begin
      @(posedge clk); #1;
      set_op(tbl[i].rq, tbl[i].a, tbl[i].b);
      req_valid = 4'(1 << tbl[i].rq);
      wait_grant(g);
      check("t3_grant", g, tbl[i].rq);
      push(tbl[i].rq, tbl[i].prod);
      @(posedge clk); #1;
      req_valid = '0;
      wait_drain();
    end
    noise_en = 1'b0;

    // Response backpressure for 20 cycles with another requester waiting.
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    set_op(1, 7, 3);
    req_valid = 4'b0010;
    wait_grant(g);
    check("t4_grant", g, 1);
    push(1, 21);
    @(posedge clk); #1;
    set_op(0, 6, 6);
    req_valid = 4'b0001;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (rsp_valid) found = 1'b1;
    end
    if (!found) fail_now("t4_rsp_timeout");
    p0 = int'(rsp_product);
    i0 = int'(rsp_id);
    check("t4_prod_held", p0, 21);
    check("t4_id_held", i0, 1);
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      if (j > 0) @(negedge clk);
      if (!rsp_valid || int'(rsp_product) != p0 || int'(rsp_id) != i0 || req_ready != 0) bad++;
    end
    check("t4_stall_stable", bad, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_grant(g);
    check("t4_next_grant", g, 0);
    push(0, 36);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();
`ifdef UNARY_MULT_SCHED_PERF_EN
    check("t4_perf_stall", perf_stall, 20);
    check("t4_perf_jobs", perf_jobs, jobs_since_reset);
`endif

    // Reset mid-FEED, then requester 1 withdraws while 3 waits.
    @(posedge clk); #1;
    set_op(2, 9, 9);
    req_valid = 4'b0100;
    wait_grant(g);
    check("t5_grant", g, 2);
    push(2, 81);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    check("t5_pre_feed_valid", mult_valid, 1);
    check("t5_pre_feed_a", mult_a, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_mult_valid", mult_valid, 0);
    check("t5_rst_mult_a", mult_a, 0);
    check("t5_rst_rsp_valid", rsp_valid, 0);
    sb.delete();
    jobs_since_reset = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    set_op(0, 2, 2);
    set_op(3, 13, 1);
    req_valid = 4'b1001;
    wait_grant(g);
    check("t5_ptr_reset", g, 0);
    push(0, 4);
    @(posedge clk); #1;
    req_valid = 4'b1010;
    repeat (10) @(posedge clk);
    #1;
    req_valid = 4'b1000;
    wait_grant(g);
    check("t6_skip_dropped", g, 3);
    push(3, 13);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();
    check("t6_jobs_after_reset", jobs_since_reset, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
